// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser capture path: default RAM depth,
// address width derivation and the capture sequencer state encoding.
package la_pkg;

  localparam int unsigned DEPTH_DEF  = 384;
  localparam int unsigned ADDR_W_DEF = $clog2(DEPTH_DEF);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRETRIG  = 3'd1,
    ARMED    = 3'd2,
    POSTTRIG = 3'd3,
    DONE     = 3'd4
  } cap_state_t;

endpackage

// File: rtl/capture_ctrl_if.sv
// Control/status bundle between the command/trigger side (master) and the
// capture sequencer (slave), including the sample RAM write port.
interface capture_ctrl_if
  import la_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic              cap_en;
  logic              wrt_smpl;
  logic              triggered;
  logic [ADDR_W-1:0] trig_pos;
  logic              cap_done_clr;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic              armed;
  logic              set_capture_done;
  logic              capture_done;
  logic [ADDR_W-1:0] start_addr;

  modport master (
    output cap_en, wrt_smpl, triggered, trig_pos, cap_done_clr,
    input  we, waddr, armed, set_capture_done, capture_done, start_addr
  );

  modport slave (
    input  cap_en, wrt_smpl, triggered, trig_pos, cap_done_clr,
    output we, waddr, armed, set_capture_done, capture_done, start_addr
  );

endinterface

// File: rtl/capture_ctrl_ptr.sv
// Modulo-DEPTH address counter with synchronous clear and increment; also
// exposes the wrapped next value so callers can see the post-write pointer.
module cap_ptr
  import la_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr,
  output logic [ADDR_W-1:0] ptr_nxt_c
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  // DEPTH need not be a power of two, so wrap explicitly at the last entry
  always_comb ptr_nxt_c = (ptr == LAST) ? '0 : ptr + ADDR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ptr_nxt_c;
  end

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer: fills the pre-trigger window, arms, waits for the trigger,
// writes the post-trigger remainder and holds DONE until the host acknowledges.
module capture_ctrl
  import la_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  capture_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  cap_state_t        state, state_nxt;
  logic [ADDR_W-1:0] trig_q, trig_clamp_c;
  logic [ADDR_W-1:0] waddr_q, ptr_nxt_c, start_q;
  logic [CNT_W-1:0]  pre_cnt, post_cnt;
  logic              ptr_clr, ptr_inc, pre_clr, pre_inc, post_load, post_dec, trig_load;
  logic              write_st_c, we_c, done_entry_c;
  logic              armed_q, set_done_q, cap_done_q;

  assign trig_clamp_c = (CNT_W'(bus.trig_pos) >= CNT_W'(DEPTH)) ? ADDR_W'(DEPTH - 1)
                                                                  : bus.trig_pos;
  assign write_st_c   = (state == PRETRIG) || (state == ARMED) || (state == POSTTRIG);
  // Gating with cap_en keeps the abort cycle from writing
  assign we_c         = bus.wrt_smpl & bus.cap_en & write_st_c;
  assign done_entry_c = (state_nxt == DONE) && (state != DONE);

  cap_ptr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_waddr (
    .clk       (clk),
    .rst       (rst),
    .clr       (ptr_clr),
    .inc       (ptr_inc),
    .ptr       (waddr_q),
    .ptr_nxt_c (ptr_nxt_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ptr_clr   = 1'b0;
    ptr_inc   = 1'b0;
    pre_clr   = 1'b0;
    pre_inc   = 1'b0;
    post_load = 1'b0;
    post_dec  = 1'b0;
    trig_load = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cap_en) begin
          ptr_clr   = 1'b1;
          pre_clr   = 1'b1;
          trig_load = 1'b1;
          state_nxt = (trig_clamp_c == '0) ? ARMED : PRETRIG;
        end
      end
      PRETRIG: begin
        if (!bus.cap_en) begin
          state_nxt = IDLE;
        end else if (we_c) begin
          ptr_inc = 1'b1;
          pre_inc = 1'b1;
          if (pre_cnt + CNT_W'(1) == CNT_W'(trig_q)) state_nxt = ARMED;
        end
      end
      ARMED: begin
        if (!bus.cap_en) begin
          state_nxt = IDLE;
        end else begin
          // A write alongside the trigger still belongs to the pre-trigger window
          ptr_inc = we_c;
          if (bus.triggered) begin
            post_load = 1'b1;
            state_nxt = POSTTRIG;
          end
        end
      end
      POSTTRIG: begin
        if (!bus.cap_en) begin
          state_nxt = IDLE;
        end else if (we_c) begin
          ptr_inc  = 1'b1;
          post_dec = 1'b1;
          if (post_cnt == CNT_W'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.cap_done_clr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_q   <= '0;
      pre_cnt  <= '0;
      post_cnt <= '0;
    end else begin
      if (trig_load) trig_q <= trig_clamp_c;
      if (pre_clr)        pre_cnt <= '0;
      else if (pre_inc)   pre_cnt <= pre_cnt + CNT_W'(1);
      if (post_load)      post_cnt <= CNT_W'(DEPTH) - CNT_W'(trig_q);
      else if (post_dec)  post_cnt <= post_cnt - CNT_W'(1);
    end
  end

  // Status flags track the state being entered so they align with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q    <= 1'b0;
      set_done_q <= 1'b0;
      cap_done_q <= 1'b0;
      start_q    <= '0;
    end else begin
      armed_q    <= (state_nxt == ARMED);
      set_done_q <= done_entry_c;
      cap_done_q <= (state_nxt == DONE);
      if (done_entry_c) start_q <= ptr_nxt_c;
    end
  end

  assign bus.we               = we_c;
  assign bus.waddr            = waddr_q;
  assign bus.armed            = armed_q;
  assign bus.set_capture_done = set_done_q;
  assign bus.capture_done     = cap_done_q;
  assign bus.start_addr       = start_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: a DEPTH=6 instance for sequencing corners
// and a DEPTH=384 instance for a full-size capture with address wrap.
module tb_capture_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  capture_ctrl_if #(.ADDR_W(3)) bus_s ();
  capture_ctrl_if #(.ADDR_W(9)) bus_b ();

  capture_ctrl #(.DEPTH(6), .ADDR_W(3)) u_dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s.slave)
  );

  capture_ctrl #(.DEPTH(384), .ADDR_W(9)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int          cnt;
  logic [8:0]  max_a;
  logic [8:0]  prev_a;
  logic        saw_wrap;
  logic [2:0]  exp_a [5];
  logic [2:0]  exp_p [4];

  initial begin
    bus_s.cap_en = 1'b0; bus_s.wrt_smpl = 1'b0; bus_s.triggered = 1'b0;
    bus_s.trig_pos = '0; bus_s.cap_done_clr = 1'b0;
    bus_b.cap_en = 1'b0; bus_b.wrt_smpl = 1'b0; bus_b.triggered = 1'b0;
    bus_b.trig_pos = '0; bus_b.cap_done_clr = 1'b0;
    exp_a = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    exp_p = '{3'd2, 3'd3, 3'd4, 3'd5};

    step(); step();
    check("rst_waddr", 32'(bus_s.waddr), 0);
    check("rst_armed", 32'(bus_s.armed), 0);
    check("rst_done", 32'(bus_s.capture_done), 0);
    check("rst_set", 32'(bus_s.set_capture_done), 0);
    check("rst_start", 32'(bus_s.start_addr), 0);
    rst = 1'b0;

    // Pre-trigger fill with trig_pos=2, then free-running armed writes
    bus_s.trig_pos = 3'd2; bus_s.cap_en = 1'b1;
    step();
    check("pre_waddr0", 32'(bus_s.waddr), 0);
    check("pre_armed0", 32'(bus_s.armed), 0);
    bus_s.wrt_smpl = 1'b1;
    #1 check("pre_we", 32'(bus_s.we), 1);
    step();
    check("pre_waddr1", 32'(bus_s.waddr), 1);
    check("pre_armed1", 32'(bus_s.armed), 0);
    step();
    check("armed_after2", 32'(bus_s.armed), 1);
    for (int i = 0; i < 5; i++) begin
      check("armed_waddr", 32'(bus_s.waddr), 32'(exp_a[i]));
      step();
    end
    check("armed_wrap", 32'(bus_s.waddr), 1);

    // Trigger at waddr=1: four post writes, then DONE
    bus_s.triggered = 1'b1;
    check("trig_we", 32'(bus_s.we), 1);
    step();
    bus_s.triggered = 1'b0;
    check("post_armed", 32'(bus_s.armed), 0);
    for (int i = 0; i < 4; i++) begin
      check("post_set_low", 32'(bus_s.set_capture_done), 0);
      check("post_waddr", 32'(bus_s.waddr), 32'(exp_p[i]));
      step();
    end
    check("done_set", 32'(bus_s.set_capture_done), 1);
    check("done_flag", 32'(bus_s.capture_done), 1);
    check("done_start", 32'(bus_s.start_addr), 0);
    check("done_we", 32'(bus_s.we), 0);
    step();
    check("done_set_pulse", 32'(bus_s.set_capture_done), 0);
    check("done_hold", 32'(bus_s.capture_done), 1);
    check("done_frozen", 32'(bus_s.waddr), 0);
    bus_s.cap_en = 1'b0;
    step();
    check("done_ignore_en", 32'(bus_s.capture_done), 1);
    bus_s.cap_en = 1'b1;

    // Acknowledge, automatic restart, then abort while ARMED
    bus_s.cap_done_clr = 1'b1;
    step();
    bus_s.cap_done_clr = 1'b0;
    check("clr_done", 32'(bus_s.capture_done), 0);
    check("idle_we", 32'(bus_s.we), 0);
    step();
    check("restart_waddr", 32'(bus_s.waddr), 0);
    step(); step();
    check("restart_armed", 32'(bus_s.armed), 1);
    bus_s.cap_en = 1'b0;
    #1 check("abort_arm_we", 32'(bus_s.we), 0);
    step();
    check("abort_arm_armed", 32'(bus_s.armed), 0);
    check("abort_arm_waddr", 32'(bus_s.waddr), 2);
    check("abort_arm_set", 32'(bus_s.set_capture_done), 0);

    // trig_pos=0 arms immediately; trigger yields a full DEPTH of post writes
    bus_s.wrt_smpl = 1'b0; bus_s.trig_pos = 3'd0; bus_s.cap_en = 1'b1;
    step();
    check("tp0_armed", 32'(bus_s.armed), 1);
    check("tp0_waddr", 32'(bus_s.waddr), 0);
    bus_s.trig_pos = 3'd5;
    bus_s.wrt_smpl = 1'b1; bus_s.triggered = 1'b1;
    step();
    bus_s.triggered = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus_s.capture_done) break;
      if (bus_s.we) cnt++;
      step();
    end
    check("tp0_post_writes", 32'(cnt), 6);
    check("tp0_done", 32'(bus_s.capture_done), 1);
    check("tp0_set", 32'(bus_s.set_capture_done), 1);
    check("tp0_start", 32'(bus_s.start_addr), 1);
    bus_s.cap_en = 1'b0; bus_s.cap_done_clr = 1'b1;
    step();
    bus_s.cap_done_clr = 1'b0;

    // trig_pos=7 clamps to 5, then abort in POSTTRIG
    bus_s.trig_pos = 3'd7; bus_s.cap_en = 1'b1;
    step();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus_s.armed) break;
      if (bus_s.we) cnt++;
      step();
    end
    check("clamp_pre_writes", 32'(cnt), 5);
    check("clamp_waddr", 32'(bus_s.waddr), 5);
    bus_s.triggered = 1'b1;
    step();
    bus_s.triggered = 1'b0;
    check("clamp_post_waddr", 32'(bus_s.waddr), 0);
    bus_s.cap_en = 1'b0;
    #1 check("abort_post_we", 32'(bus_s.we), 0);
    step();
    check("abort_post_waddr", 32'(bus_s.waddr), 0);
    check("abort_post_set", 32'(bus_s.set_capture_done), 0);
    check("abort_post_done", 32'(bus_s.capture_done), 0);
    bus_s.wrt_smpl = 1'b0; bus_s.trig_pos = 3'd0; bus_s.cap_en = 1'b1;
    step();
    check("abort_post_idle", 32'(bus_s.armed), 1);

    // Asynchronous reset in the middle of POSTTRIG
    bus_s.wrt_smpl = 1'b1; bus_s.triggered = 1'b1;
    step();
    bus_s.triggered = 1'b0;
    step();
    check("mid_waddr", 32'(bus_s.waddr), 2);
    #2 rst = 1'b1;
    #1;
    check("arst_waddr", 32'(bus_s.waddr), 0);
    check("arst_we", 32'(bus_s.we), 0);
    check("arst_armed", 32'(bus_s.armed), 0);
    check("arst_done", 32'(bus_s.capture_done), 0);
    check("arst_start", 32'(bus_s.start_addr), 0);
    step();
    rst = 1'b0; bus_s.cap_en = 1'b0; bus_s.wrt_smpl = 1'b0;
    step();
    check("arst_idle", 32'(bus_s.armed), 0);

    // Full-size capture: trig_pos=100 leaves 284 post-trigger writes
    bus_b.trig_pos = 9'd100; bus_b.cap_en = 1'b1; bus_b.wrt_smpl = 1'b1;
    step();
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      if (bus_b.armed) break;
      if (bus_b.we) cnt++;
      step();
    end
    check("big_pre_writes", 32'(cnt), 100);
    check("big_armed_waddr", 32'(bus_b.waddr), 100);
    max_a = '0; saw_wrap = 1'b0;
    for (int i = 0; i < 300; i++) begin
      prev_a = bus_b.waddr;
      step();
      if (bus_b.waddr > max_a) max_a = bus_b.waddr;
      if (prev_a == 9'd383 && bus_b.waddr == 9'd0) saw_wrap = 1'b1;
    end
    check("big_max_addr", 32'(max_a), 383);
    check("big_wrap", 32'(saw_wrap), 1);
    check("big_wrap_waddr", 32'(bus_b.waddr), 16);
    bus_b.triggered = 1'b1;
    step();
    bus_b.triggered = 1'b0;
    check("big_trig_waddr", 32'(bus_b.waddr), 17);
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      if (bus_b.capture_done) break;
      if (bus_b.we) cnt++;
      step();
    end
    check("big_post_writes", 32'(cnt), 284);
    check("big_set", 32'(bus_b.set_capture_done), 1);
    check("big_start", 32'(bus_b.start_addr), 301);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
